// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter
// Arbitrates NUM_SRC interrupt sources onto a single request line to the core.
// The core sees one committed interrupt at a time. It acknowledges that
// interrupt with int_rst_i. The arbiter then returns a one-cycle completion
// pulse on int_fin_o to the source that was serviced.
// Arbitration is fixed priority (RR_MODE=0, lowest index wins) or
// round-robin (RR_MODE=1).
// Optional feature macro: IRQ_EDGE_CAPTURE_EN.
//   Defined:   requests are captured on rising edges into a pending register.
//   Undefined: requests are level-sensitive.
module interrupt_arbiter #(
  parameter int NUM_SRC = 32,
  parameter int RR_MODE = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] int_req_i,
  input  logic [NUM_SRC-1:0] mie_i,
  input  logic               int_rst_i,
  output logic               int_o,
  output logic [NUM_SRC-1:0] int_fin_o,
  output logic [31:0]        mcause_o
);

  localparam int IDW = $clog2(NUM_SRC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               int_q, int_d;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] fin_vec;
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic               grant;
  logic [4:0]         id_ext;

`ifdef IRQ_EDGE_CAPTURE_EN
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] req_q;

  // A rising edge sets a pending bit, and the completion of that source clears it.
  // When both happen in the same cycle, the set wins so that no edge is lost.
  always_comb begin
    pend_d = (pend_q & ~fin_vec) | (int_req_i & ~req_q);
  end

  // Pending bits and the previous request sample used for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      req_q  <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= int_req_i;
    end
  end

  assign pend = pend_q;
`else
  assign pend = int_req_i;
`endif

  assign elig = pend & mie_i;

  // Winner search: scan from index 0 (fixed) or from ptr+1 with wrap (round-robin).
  always_comb begin
    int base;
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    base      = 0;
    idx       = 0;
    if (RR_MODE != 0) begin
      base = int'(ptr_q) + 1;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (base + k) % NUM_SRC;
      if (!win_found && elig[idx[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[IDW-1:0];
      end
    end
  end

  // Next-state logic. Once a request has been granted it is committed until the core completes it.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    grant   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant   = 1'b1;
          id_d    = win_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (int_rst_i) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The round-robin pointer follows the most recent grant. In fixed mode it stays frozen.
  always_comb begin
    ptr_d = ptr_q;
    if (grant && (RR_MODE != 0)) begin
      ptr_d = win_idx;
    end
  end

  // int_o is taken straight from a flop that is set exactly when the FSM is heading into REQ.
  always_comb begin
    int_d = (state_d == S_REQ);
  end

  // Control and index registers. Reset abandons any transaction that is in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      ptr_q   <= IDW'(NUM_SRC - 1);
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      int_q   <= int_d;
    end
  end

  // One-hot completion pulse toward the serviced source, valid only in FIN.
  always_comb begin
    fin_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fin_vec[i] = (state_q == S_FIN) && (id_q == IDW'(i));
    end
  end

  // Cause word: interrupt flag in bit 31 and the 5-bit source id; zero when idle.
  always_comb begin
    id_ext            = '0;
    id_ext[IDW-1:0]   = id_q;
    mcause_o          = 32'h0;
    if (int_q) begin
      mcause_o = {1'b1, 26'h0, id_ext};
    end
  end

  assign int_o     = int_q;
  assign int_fin_o = fin_vec;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Testbench for interrupt_arbiter.
// Runs a fixed-priority instance and a round-robin instance side by side.
// Both instances share the same input stimulus.
// Their outputs are compared against a transaction-level reference model.
module tb_interrupt_arbiter;

  localparam int N = 32;
`ifdef IRQ_EDGE_CAPTURE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      mie = '0;
  logic              irst = 1'b0;
  logic [1:0]        int_o_w;
  logic [1:0][N-1:0] fin_w;
  logic [1:0][31:0]  mc_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  interrupt_arbiter #(.NUM_SRC(N), .RR_MODE(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .int_req_i(req), .mie_i(mie), .int_rst_i(irst),
    .int_o(int_o_w[0]), .int_fin_o(fin_w[0]), .mcause_o(mc_w[0]));

  interrupt_arbiter #(.NUM_SRC(N), .RR_MODE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .int_req_i(req), .mie_i(mie), .int_rst_i(irst),
    .int_o(int_o_w[1]), .int_fin_o(fin_w[1]), .mcause_o(mc_w[1]));

  // Reference model: one entry per arbitration mode.
  bit          m_busy [2];
  bit          m_done [2];
  int          m_id   [2];
  int          m_last [2];
  logic [31:0] m_pend [2];
  logic [31:0] m_prev [2];

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 1'b0;
      m_done[m] = 1'b0;
      m_id[m]   = 0;
      m_last[m] = N - 1;
      m_pend[m] = '0;
      m_prev[m] = '0;
    end
  endfunction

  function automatic int pick(int m, logic [31:0] elig);
    int start;
    int idx;
    start = (m == 1) ? m_last[m] + 1 : 0;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge, using the inputs present at that edge.
  function automatic void model_step(logic [31:0] r, logic [31:0] en, logic ack);
    logic [31:0] elig;
    bit          was_busy;
    bit          was_done;
    int          w;
    for (int m = 0; m < 2; m++) begin
      elig     = (EDGE ? m_pend[m] : r) & en;
      was_busy = m_busy[m];
      was_done = m_done[m];
      if (EDGE) begin
        m_pend[m] = (m_pend[m] & ~(was_done ? (32'h1 << m_id[m]) : 32'h0)) | (r & ~m_prev[m]);
        m_prev[m] = r;
      end
      m_done[m] = was_busy && ack;
      if (was_busy) begin
        m_busy[m] = !ack;
      end else if (!was_done) begin
        w = pick(m, elig);
        if (w >= 0) begin
          m_busy[m] = 1'b1;
          m_id[m]   = w;
          if (m == 1) m_last[m] = w;
        end
      end
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d_int_o", m), {31'h0, int_o_w[m]}, {31'h0, m_busy[m]});
      chk($sformatf("m%0d_mcause", m), mc_w[m],
          m_busy[m] ? (32'h8000_0000 | m_id[m]) : 32'h0);
      chk($sformatf("m%0d_fin", m), fin_w[m],
          m_done[m] ? (32'h1 << m_id[m]) : 32'h0);
    end
  endtask

  task automatic tick();
    model_step(req, mie, irst);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Outputs during reset
    chk("rst_int_o", {31'h0, int_o_w[0]}, 32'h0);
    chk("rst_mcause", mc_w[0], 32'h0);
    chk("rst_fin", fin_w[0], 32'h0);
    check_model();
    rst_ni = 1'b1;

`ifndef IRQ_EDGE_CAPTURE_EN
    // Fixed priority: lowest set index wins, and the completion pulse goes to that source
    mie = '1;
    req = 32'h0000_0014;
    tick();
    chk("fp_int_o", {31'h0, int_o_w[0]}, 32'h1);
    chk("fp_mcause", mc_w[0], 32'h8000_0002);
    irst = 1'b1;
    tick();
    irst = 1'b0;
    chk("fp_fin", fin_w[0], 32'h0000_0004);
    tick();
    chk("fp_fin_once", fin_w[0], 32'h0);
    req = '0;
    tick();

    // Round-robin over three held requests, wrapping back to 0
    do_reset();
    req = 32'h0000_0007;
    mie = '1;
    tick();
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("rr_grant%0d", r), mc_w[1], 32'h8000_0000 | (r % 3));
      irst = 1'b1;
      tick();
      irst = 1'b0;
      tick();
      tick();
    end
    req = '0;
    tick();
`else
    // Edge captured while masked, serviced once unmasked, then cleared
    do_reset();
    mie = '0;
    req = 32'h1 << 5;
    tick();
    req = '0;
    tick();
    tick();
    chk("edge_masked_int_o", {31'h0, int_o_w[0]}, 32'h0);
    mie = 32'h1 << 5;
    tick();
    chk("edge_int_o", {31'h0, int_o_w[0]}, 32'h1);
    chk("edge_mcause", mc_w[0], 32'h8000_0005);
    irst = 1'b1;
    tick();
    irst = 1'b0;
    chk("edge_fin", fin_w[0], 32'h1 << 5);
    repeat (3) tick();
    chk("edge_cleared", {31'h0, int_o_w[0]}, 32'h0);

    // New edge during FIN keeps the source pending, so it is re-granted at M+3
    mie = '1;
    req = 32'h1 << 3;
    tick();
    tick();
    chk("refire_first", mc_w[0], 32'h8000_0003);
    req = '0;
    tick();
    irst = 1'b1;
    tick();
    irst = 1'b0;
    req = 32'h1 << 3;
    chk("refire_fin", fin_w[0], 32'h1 << 3);
    tick();
    chk("refire_idle", {31'h0, int_o_w[0]}, 32'h0);
    tick();
    chk("refire_regrant", mc_w[0], 32'h8000_0003);
    irst = 1'b1;
    tick();
    irst = 1'b0;
    req = '0;
    tick();
`endif

    // Committed grant survives removal of both the request and its enable
    do_reset();
    req = '0;
    mie = '1;
    tick();
    req = 32'h1 << 3;
    tick();
    if (EDGE) tick();
    chk("commit_grant", mc_w[0], 32'h8000_0003);
    req = '0;
    mie = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("commit_hold%0d", i), mc_w[0], 32'h8000_0003);
    end
    irst = 1'b1;
    tick();
    irst = 1'b0;
    chk("commit_fin", fin_w[0], 32'h1 << 3);
    tick();

    // Asynchronous reset in the middle of REQ abandons the transaction
    mie = '1;
    req = 32'h1 << 3;
    tick();
    if (EDGE) tick();
    chk("areset_pre", {31'h0, int_o_w[0]}, 32'h1);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("areset_int_o", {31'h0, int_o_w[0]}, 32'h0);
    chk("areset_mcause", mc_w[1], 32'h0);
    chk("areset_fin", fin_w[0], 32'h0);
    @(posedge clk);
    #1;
    check_model();
    req = '0;
    rst_ni = 1'b1;
    irst = 1'b1;
    tick();
    irst = 1'b0;
    chk("areset_nofin0", fin_w[0], 32'h0);
    chk("areset_nofin1", fin_w[1], 32'h0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      req  = $urandom & $urandom & $urandom;
      mie  = ~($urandom & $urandom);
      irst = ($urandom_range(0, 3) == 0);
      tick();
    end
    irst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
